// File: rtl/iram_fetch_arbiter.sv
// Round-robin arbiter sharing one synchronous-read IRAM port among core fetch units.
// The grant is combinational; read data returns one cycle later, tagged with the winning core.
module iram_fetch_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    localparam int ID_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_CORES-1:0]        i_req,
    input  logic [NUM_CORES*ADDR_W-1:0] i_req_addr,
    output logic [NUM_CORES-1:0]        o_gnt,
    output logic [NUM_CORES-1:0]        o_rvalid,
    output logic [DATA_W-1:0]           o_rdata,
    output logic [ID_W-1:0]             o_gnt_id,
    output logic [ADDR_W-1:0]           o_iram_addr,
    input  logic [DATA_W-1:0]           i_iram_rdata
);

    logic [ID_W-1:0] r_last;
    logic            r_pend_valid;
    logic [ID_W-1:0] r_pend_id;

    logic            w_found;
    logic [ID_W-1:0] w_win;
    int              w_idx;

    // Scan from the core after the last winner, so the most recent winner has the lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int off = 1; off <= NUM_CORES; off++) begin
            w_idx = (int'(r_last) + off) % NUM_CORES;
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_win   = ID_W'(w_idx);
            end
        end
    end

    always_comb begin
        o_gnt       = '0;
        o_iram_addr = '0;
        if (w_found && !i_rst) begin
            o_gnt[w_win] = 1'b1;
            o_iram_addr  = i_req_addr[int'(w_win)*ADDR_W +: ADDR_W];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last       <= ID_W'(NUM_CORES - 1);
            r_pend_valid <= 1'b0;
            r_pend_id    <= '0;
        end else begin
            r_pend_valid <= w_found;
            if (w_found) begin
                r_last    <= w_win;
                r_pend_id <= w_win;
            end
        end
    end

    always_comb begin
        o_rvalid = '0;
        if (r_pend_valid) o_rvalid[r_pend_id] = 1'b1;
    end

    assign o_gnt_id = r_pend_id;
    assign o_rdata  = i_iram_rdata;

endmodule

// File: doc/iram_fetch_arbiter.md
# iram_fetch_arbiter

Shares the single synchronous-read port of the instruction RAM among the processor cores' fetch units. Each cycle it grants at most one pending fetch request by round-robin, drives that core's address onto the IRAM port, and returns the IRAM data one cycle later tagged to the winning core. It sits between the per-core fetch stages and the IRAM, with no buffering beyond the one-cycle read pipeline.

## Interface
- NUM_CORES, 4, number of requesting cores (2..8)
- ADDR_W, 16, fetch address width
- DATA_W, 16, instruction word width
- ID_W, clog2(NUM_CORES), width of grant index (derived, not overridable)

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_CORES  per-core fetch request; held high until granted
- req_addr  in  NUM_CORES*ADDR_W  per-core fetch address; core i at bits [i*ADDR_W +: ADDR_W]
- gnt  out  NUM_CORES  one-hot grant, combinational, same cycle as accepted req
- rvalid  out  NUM_CORES  one-hot, registered; read data for core i valid this cycle
- rdata  out  DATA_W  shared return bus; qualified by rvalid
- gnt_id  out  ID_W  registered index of the core whose data is on rdata
- iram_addr  out  ADDR_W  address to IRAM port
- iram_rdata  in  DATA_W  IRAM output, valid one cycle after iram_addr sampled

## Operation
- State: round-robin pointer `last` (ID_W bits) = index of most recent grant; pipeline register `pend_valid`, `pend_id`.
- Arbitration each cycle: scan cores last+1, last+2, ... cyclically (mod NUM_CORES); first with req=1 wins. Exactly one gnt bit high if any req high, else gnt=0.
- On a grant to core k: iram_addr = req_addr[k]; at the clock edge last<=k, pend_valid<=1, pend_id<=k.
- No request: iram_addr = 0, last unchanged, pend_valid<=0.
- Return: rvalid[pend_id] = pend_valid; gnt_id = pend_id; rdata = iram_rdata (pass-through).
- A core seeing gnt high in cycle T deasserts or changes req/req_addr for T+1; a new req in T+1 is arbitrated normally (no lockout of the same core except by rotation).
- Fairness: a continuously requesting core is granted within NUM_CORES cycles.
- Single requester streams at one fetch per cycle.
- NUM_CORES not a power of two: pointer wraps from NUM_CORES-1 to 0; indices >= NUM_CORES never granted.

## Timing
- Reset (async assert, synchronous-safe deassert by system): last = NUM_CORES-1 (core 0 highest priority first), pend_valid=0, pend_id=0; hence rvalid=0, gnt_id=0. gnt forced to 0 and iram_addr to 0 while rst high.
- rdata during/after reset mirrors iram_rdata; meaningless unless rvalid.
- Latency: req sampled with gnt in cycle T; IRAM captures iram_addr at edge ending T; rvalid and rdata valid in T+1. Fixed 1-cycle grant-to-data latency, throughput 1 word/cycle.
- Reset asserted with a read in flight: pend_valid cleared immediately; no rvalid issued for that read; the core must re-request.
- Simultaneous req from all cores: grants rotate k, k+1, ... each cycle, no gaps.
- req changing in the same cycle as gnt: grant decision uses the current-cycle values (combinational path req -> gnt -> iram_addr must close within one cycle).

## Test plan
- Reset: hold rst with req=4'b1111 -> gnt=0, rvalid=0, iram_addr=0; release, first cycle gnt=4'b0001, iram_addr=req_addr[0].
- Single core: core 2 requests addrs 0,1,2,3 back-to-back with IRAM preloaded (ram[0]=45, ram[1]=5, ram[2]=51, ram[3]=10) -> gnt=4'b0100 each cycle; rvalid=4'b0100 one cycle later with rdata 45,5,51,10 in order, gnt_id=2.
- All four cores request continuously, each a different address -> grant order 0,1,2,3,0,...; each rdata matches its core's address contents; no idle cycle.
- Fairness: core 0 and core 3 request continuously, cores 1,2 idle -> grants alternate 0,3,0,3; neither waits more than 1 cycle.
- Reset mid-flight: grant core 1 in cycle T, assert rst in T+1 before edge -> rvalid stays 0; after release, pointer restarts with core 0 priority.
- Idle gaps: req=0 for 3 cycles between grants -> gnt=0, rvalid=0 in the following cycles, last unchanged (next winner is successor of last granted core).
